// File: rtl/load_store_unit_if.sv
// Core/memory-facing bundle of the load/store unit.
// Handshake: the core raises Req with Wr/Funct3/Addr/StoreData; the unit takes
// it only on a clock edge where Ready=1, and a request seen while Ready=0 is
// dropped, not queued. Completion is a single-cycle Done pulse, qualified by
// Misaligned/Illegal. Memory reads are combinational from MemAddr; the memory
// writes MemWData on a rising edge while MemW=1.
interface load_store_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              Req;
  logic              Wr;
  logic [2:0]        Funct3;
  logic [31:0]       Addr;
  logic [DATA_W-1:0] StoreData;
  logic              Ready;
  logic              Done;
  logic [DATA_W-1:0] LoadData;
  logic              Misaligned;
  logic              Illegal;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemW;
  logic [DATA_W-1:0] MemRData;

  // Core plus memory model side.
  modport master (
    output Req, Wr, Funct3, Addr, StoreData, MemRData,
    input  Ready, Done, LoadData, Misaligned, Illegal, MemAddr, MemWData, MemW
  );

  // Load/store unit side.
  modport slave (
    input  Req, Wr, Funct3, Addr, StoreData, MemRData,
    output Ready, Done, LoadData, Misaligned, Illegal, MemAddr, MemWData, MemW
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide memory with no byte enables.
// Sub-word stores are done as read-modify-write. Faulting requests finish in
// one cycle and never reach the memory.
module load_store_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  load_store_unit_if.slave       bus,
  output logic [1:0]             DbgState
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RMW_RD = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              done_q, done_d;
  logic              misaligned_q, misaligned_d;
  logic              illegal_q, illegal_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic req_illegal;
  logic req_misaligned;

  // Address bits above the word index alias onto the same memory word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Addr[31:ADDR_W+2];

  // Lane extraction with sign/zero extension for the five load flavours.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] word,
    input logic [2:0]        f3,
    input logic [1:0]        lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    load_extract = {{24{b[7]}}, b};
      3'd1:    load_extract = {{16{h[15]}}, h};
      3'd4:    load_extract = {24'd0, b};
      3'd5:    load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace one byte or halfword of the old memory word with store data.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] sdata,
    input logic [2:0]        f3,
    input logic [1:0]        lane
  );
    logic [DATA_W-1:0] r;
    r = word;
    if (f3[1:0] == 2'b00) begin
      r[{lane, 3'b000} +: 8] = sdata[7:0];
    end else if (lane[1]) begin
      r[31:16] = sdata[15:0];
    end else begin
      r[15:0] = sdata[15:0];
    end
    store_merge = r;
  endfunction

  // Classify the incoming request; the illegal check has priority over alignment.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (bus.Wr) begin
      req_illegal = (bus.Funct3 >= 3'd3);
    end else begin
      req_illegal = (bus.Funct3 == 3'd3) || (bus.Funct3[2:1] == 2'b11);
    end
    req_misaligned = ((bus.Funct3[1:0] == 2'b01) && bus.Addr[0]) ||
                     ((bus.Funct3[1:0] == 2'b10) && (bus.Addr[1:0] != 2'b00));
  end

  // Next-state and datapath updates for the request FSM.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    funct3_d     = funct3_q;
    store_data_d = store_data_q;
    load_data_d  = load_data_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          lane_d       = bus.Addr[1:0];
          funct3_d     = bus.Funct3;
          store_data_d = bus.StoreData;
          mem_addr_d   = bus.Addr[ADDR_W+1:2];
          if (req_illegal) begin
            illegal_d = 1'b1;
            done_d    = 1'b1;
          end else if (req_misaligned) begin
            misaligned_d = 1'b1;
            done_d       = 1'b1;
          end else if (!bus.Wr) begin
            state_d = S_LOAD;
          end else if (bus.Funct3 == 3'd2) begin
            mem_wdata_d = bus.StoreData;
            state_d     = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        load_data_d = load_extract(bus.MemRData, funct3_q, lane_q);
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      S_RMW_RD: begin
        mem_wdata_d = store_merge(bus.MemRData, store_data_q, funct3_q, lane_q);
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any pending request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      funct3_q     <= 3'd0;
      store_data_q <= '0;
      load_data_q  <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      funct3_q     <= funct3_d;
      store_data_q <= store_data_d;
      load_data_q  <= load_data_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Write enable is gated by reset so an interrupted store never lands.
  assign bus.Ready      = (state_q == S_IDLE);
  assign bus.MemW       = (state_q == S_WRITE) && !RST;
  assign bus.Done       = done_q;
  assign bus.LoadData   = load_data_q;
  assign bus.Misaligned = misaligned_q;
  assign bus.Illegal    = illegal_q;
  assign bus.MemAddr    = mem_addr_q;
  assign bus.MemWData   = mem_wdata_q;
  assign DbgState       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized ops against a
// behavioural model, and hand-written back-to-back and reset sequences.
module tb_load_store_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [1:0] dbg_state;

  load_store_unit_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(10), .DATA_W(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .DbgState (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // memory model: async read, write on rising edge; bench preload port
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign bus.MemRData = mem[bus.MemAddr];

  always @(posedge CLK) begin
    if (bus.MemW) mem[bus.MemAddr] <= bus.MemWData;
    if (pre_we) mem[pre_idx] <= pre_val;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    ref_mem[idx] = val;
    @(posedge CLK); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request from an idle cycle; return cycles to Done (0 = timeout)
  // and the number of cycles MemW was seen high. Returns in the Done cycle.
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, output int lat, output int mw);
    bus.Req = 1'b1; bus.Wr = wr; bus.Funct3 = f3; bus.Addr = addr; bus.StoreData = sd;
    @(posedge CLK); #1;
    bus.Req = 1'b0;
    bus.Wr = 1'($urandom_range(0, 1));
    bus.Funct3 = 3'($urandom_range(0, 7));
    bus.Addr = $urandom;
    bus.StoreData = $urandom;
    lat = 0;
    mw = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.MemW) mw++;
      if (bus.Done) begin
        lat = k;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  // behavioural reference model
  function automatic bit ref_illegal(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 >= 3);
    return (f3 == 3) || (f3 == 6) || (f3 == 7);
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] sd);
    logic [31:0] mask;
    int sh;
    if (f3 == 3'd2) return sd;
    if (f3 == 3'd0) begin
      sh = 8 * int'(a % 4);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * int'((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((sd << sh) & mask);
  endfunction

  // directed vector table
  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        pre;
    logic [31:0] init;
    logic [31:0] exp_ld;
    logic        exp_mis;
    logic        exp_ill;
    int          exp_lat;
    int          exp_mw;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int lat, mw;
    logic [9:0] idx;
    logic [31:0] model_ld;

    vecs[0]  = '{1'b0, 3'd2, 32'h14,   32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'd0, 32'h17,   32'h0,        1'b1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 1'b0, 2, 0, 32'h80FF1234};
    vecs[2]  = '{1'b0, 3'd4, 32'h17,   32'h0,        1'b0, 32'h0,        32'h00000080, 1'b0, 1'b0, 2, 0, 32'h80FF1234};
    vecs[3]  = '{1'b0, 3'd1, 32'h16,   32'h0,        1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 1'b0, 2, 0, 32'h80FF1234};
    vecs[4]  = '{1'b0, 3'd5, 32'h16,   32'h0,        1'b0, 32'h0,        32'h000080FF, 1'b0, 1'b0, 2, 0, 32'h80FF1234};
    vecs[5]  = '{1'b1, 3'd0, 32'h15,   32'h000000AA, 1'b1, 32'h11223344, 32'h000080FF, 1'b0, 1'b0, 3, 1, 32'h1122AA44};
    vecs[6]  = '{1'b0, 3'd2, 32'h14,   32'h0,        1'b0, 32'h0,        32'h1122AA44, 1'b0, 1'b0, 2, 0, 32'h1122AA44};
    vecs[7]  = '{1'b1, 3'd1, 32'h13,   32'h0000FFFF, 1'b1, 32'h55667788, 32'h1122AA44, 1'b1, 1'b0, 1, 0, 32'h55667788};
    vecs[8]  = '{1'b0, 3'd2, 32'h22,   32'h0,        1'b1, 32'h01020304, 32'h1122AA44, 1'b1, 1'b0, 1, 0, 32'h01020304};
    vecs[9]  = '{1'b0, 3'd3, 32'h20,   32'h0,        1'b0, 32'h0,        32'h1122AA44, 1'b0, 1'b1, 1, 0, 32'h01020304};
    vecs[10] = '{1'b0, 3'd6, 32'h03,   32'h0,        1'b1, 32'hCAFEF00D, 32'h1122AA44, 1'b0, 1'b1, 1, 0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 3'd4, 32'h21,   32'hFFFFFFFF, 1'b0, 32'h0,        32'h1122AA44, 1'b0, 1'b1, 1, 0, 32'h01020304};
    vecs[12] = '{1'b1, 3'd1, 32'h16,   32'h1234BEEF, 1'b1, 32'hAABBCCDD, 32'h1122AA44, 1'b0, 1'b0, 3, 1, 32'hBEEFCCDD};
    vecs[13] = '{1'b1, 3'd0, 32'h1007, 32'h0000005A, 1'b1, 32'h00000000, 32'h1122AA44, 1'b0, 1'b0, 3, 1, 32'h5A000000};
    vecs[14] = '{1'b0, 3'd2, 32'h1004, 32'h0,        1'b0, 32'h0,        32'h5A000000, 1'b0, 1'b0, 2, 0, 32'h5A000000};
    vecs[15] = '{1'b1, 3'd2, 32'h2C,   32'h87654321, 1'b1, 32'h00000000, 32'h5A000000, 1'b0, 1'b0, 2, 1, 32'h87654321};
    vecs[16] = '{1'b0, 3'd5, 32'h2E,   32'h0,        1'b0, 32'h0,        32'h00008765, 1'b0, 1'b0, 2, 0, 32'h87654321};
    vecs[17] = '{1'b0, 3'd0, 32'h2C,   32'h0,        1'b0, 32'h0,        32'h00000021, 1'b0, 1'b0, 2, 0, 32'h87654321};

    // reset, with an (illegal) request held during reset that must be ignored
    bus.Req = 1'b1; bus.Wr = 1'b0; bus.Funct3 = 3'd7; bus.Addr = 32'h0; bus.StoreData = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    bus.Req = 1'b0;
    RST = 1'b0;
    check("reset_ready",  32'(bus.Ready), 32'd1);
    check("reset_done",   32'(bus.Done), 32'd0);
    check("reset_ld",     bus.LoadData, 32'h0);
    check("reset_flags",  32'({bus.Misaligned, bus.Illegal}), 32'd0);
    check("reset_memw",   32'(bus.MemW), 32'd0);
    check("reset_maddr",  32'(bus.MemAddr), 32'd0);
    check("reset_wdata",  bus.MemWData, 32'h0);

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      idx = vecs[i].addr[11:2];
      if (vecs[i].pre) preload(idx, vecs[i].init);
      run_op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd, lat, mw);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_memw_cycles", i), 32'(mw), 32'(vecs[i].exp_mw));
      check($sformatf("v%0d_misaligned", i), 32'(bus.Misaligned), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_illegal", i), 32'(bus.Illegal), 32'(vecs[i].exp_ill));
      check($sformatf("v%0d_loaddata", i), bus.LoadData, vecs[i].exp_ld);
      check($sformatf("v%0d_ready_at_done", i), 32'(bus.Ready), 32'd1);
      check($sformatf("v%0d_mem", i), mem[idx], vecs[i].exp_mem);
      ref_mem[idx] = mem[idx];
      @(posedge CLK); #1;
      check($sformatf("v%0d_pulse_clear", i), 32'({bus.Done, bus.Misaligned, bus.Illegal}), 32'd0);
    end
    model_ld = bus.LoadData === 32'h00000021 ? 32'h00000021 : 32'h00000021;

    // randomized ops against the behavioural model
    for (int w = 0; w < 16; w++) preload(10'(w), $urandom);
    for (int n = 0; n < 200; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr, sd, exp_mem;
      bit          ill, mis;
      int          exp_lat, exp_mw;
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      sd   = $urandom;
      idx  = addr[11:2];
      ill  = ref_illegal(wr, f3);
      mis  = !ill && ((addr % ref_size(f3)) != 0);
      exp_mem = ref_mem[idx];
      if (ill || mis) begin
        exp_lat = 1; exp_mw = 0;
      end else if (!wr) begin
        exp_lat = 2; exp_mw = 0;
        model_ld = ref_load(ref_mem[idx], f3, addr);
      end else begin
        exp_lat = (f3 == 3'd2) ? 2 : 3; exp_mw = 1;
        exp_mem = ref_store(ref_mem[idx], f3, addr, sd);
      end
      run_op(wr, f3, addr, sd, lat, mw);
      check($sformatf("r%0d_latency", n), 32'(lat), 32'(exp_lat));
      check($sformatf("r%0d_memw_cycles", n), 32'(mw), 32'(exp_mw));
      check($sformatf("r%0d_flags", n), 32'({bus.Misaligned, bus.Illegal}), 32'({mis, ill}));
      check($sformatf("r%0d_loaddata", n), bus.LoadData, model_ld);
      check($sformatf("r%0d_mem", n), mem[idx], exp_mem);
      ref_mem[idx] = exp_mem;
    end

    // back-to-back: SW then LW in the Done cycle; Req while busy is ignored
    preload(10'd2, 32'h0);
    preload(10'd12, 32'h00000077);
    bus.Req = 1'b1; bus.Wr = 1'b1; bus.Funct3 = 3'd2; bus.Addr = 32'h8; bus.StoreData = 32'h0000CAFE;
    @(posedge CLK); #1;
    check("b2b_sw_ready_low", 32'(bus.Ready), 32'd0);
    check("b2b_sw_memw", 32'(bus.MemW), 32'd1);
    bus.Addr = 32'h30; bus.StoreData = 32'h00001111;
    @(posedge CLK); #1;
    check("b2b_sw_done", 32'(bus.Done), 32'd1);
    check("b2b_sw_ready", 32'(bus.Ready), 32'd1);
    bus.Wr = 1'b0; bus.Funct3 = 3'd2; bus.Addr = 32'h8;
    @(posedge CLK); #1;
    check("b2b_lw_ready_low", 32'(bus.Ready), 32'd0);
    check("b2b_lw_done_low", 32'(bus.Done), 32'd0);
    bus.Wr = 1'b1; bus.Addr = 32'h30; bus.StoreData = 32'h00001111;
    @(posedge CLK); #1;
    bus.Req = 1'b0;
    check("b2b_lw_done", 32'(bus.Done), 32'd1);
    check("b2b_lw_data", bus.LoadData, 32'h0000CAFE);
    check("b2b_mem2", mem[2], 32'h0000CAFE);
    @(posedge CLK); #1;
    check("b2b_idle_done", 32'(bus.Done), 32'd0);
    check("b2b_idle_ready", 32'(bus.Ready), 32'd1);
    check("b2b_mem12", mem[12], 32'h00000077);

    // reset during the WRITE cycle of an SB
    preload(10'd5, 32'h11223344);
    run_op(1'b0, 3'd2, 32'h14, 32'h0, lat, mw);
    check("rst_pre_ld", bus.LoadData, 32'h11223344);
    @(posedge CLK); #1;
    bus.Req = 1'b1; bus.Wr = 1'b1; bus.Funct3 = 3'd0; bus.Addr = 32'h15; bus.StoreData = 32'h000000AA;
    @(posedge CLK); #1;
    bus.Req = 1'b0;
    check("rst_rmw_ready", 32'(bus.Ready), 32'd0);
    @(posedge CLK); #1;
    check("rst_write_memw", 32'(bus.MemW), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_memw_gated", 32'(bus.MemW), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_ready", 32'(bus.Ready), 32'd1);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_ld", bus.LoadData, 32'h0);
    check("rst_flags", 32'({bus.Misaligned, bus.Illegal}), 32'd0);
    check("rst_memw", 32'(bus.MemW), 32'd0);
    check("rst_maddr", 32'(bus.MemAddr), 32'd0);
    check("rst_wdata", bus.MemWData, 32'h0);
    check("rst_mem5", mem[5], 32'h11223344);
    @(posedge CLK); #1;
    check("rst_no_done", 32'(bus.Done), 32'd0);
    check("rst_mem5_after", mem[5], 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-wide data memory (1024 x 32, word-addressed, single write strobe, asynchronous read).
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word loads are sign- or zero-extended. SB/SH use read-modify-write, because the memory has no byte enables.
- Flags misaligned and illegal requests without touching memory.

Parameters:
ADDR_W, 10, memory word-index width (word index = Addr[ADDR_W+1:2])
DATA_W, 32, data width; fixed at 32 for RV32

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
Req  in  1  request strobe; sampled only when Ready=1
Wr  in  1  1=store, 0=load
Funct3  in  3  RV32I funct3 (loads 0,1,2,4,5; stores 0,1,2)
Addr  in  32  byte address; bits above ADDR_W+1 ignored (aliasing)
StoreData  in  32  store source (rs2)
Ready  out  1  unit idle, request may be issued
Done  out  1  one-cycle completion pulse
LoadData  out  32  extended load result, valid while Done=1, held until next load completes
Misaligned  out  1  with Done: request misaligned, no memory effect
Illegal  out  1  with Done: unsupported Funct3, no memory effect
MemAddr  out  ADDR_W  word index to data memory
MemWData  out  32  write data to data memory
MemW  out  1  memory write enable
MemRData  in  32  memory read data (combinational from MemAddr)

Behaviour:
- Reset values: state=IDLE, Ready=1, Done=0, LoadData=0, Misaligned=0, Illegal=0, MemW=0, MemAddr=0, MemWData=0. RST overrides Req in the same cycle.
- States: IDLE, LOAD, RMW_RD, WRITE. Ready = (state==IDLE). MemW = (state==WRITE) & ~RST.
- At each IDLE edge with Req=1, latch Addr, Wr, Funct3 and StoreData. MemAddr <= Addr[11:2].
- Classification, in priority order:
  - Illegal: load Funct3 in {3,6,7}, or store Funct3 >= 3.
  - Misaligned: halfword with Addr[0]=1, or word with Addr[1:0]!=0.
  - For either fault: Done<=1 and the matching flag <=1 at the same edge; state stays IDLE; MemW never asserts.
  - Load -> LOAD; SW -> WRITE with MemWData<=StoreData; SB/SH -> RMW_RD.
- LOAD (1 cycle): sample MemRData at the edge and select the lane.
  - Byte lane: Addr[1:0]. Half lane: Addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - LoadData<=result, Done<=1, then IDLE.
- RMW_RD (1 cycle): MemWData <= MemRData with the lane replaced (SB: StoreData[7:0] into byte Addr[1:0]; SH: StoreData[15:0] into half Addr[1]), then WRITE.
- WRITE (1 cycle): MemW=1; memory captures at the edge; Done<=1, then IDLE.
- Latency from the accepting edge N:
  - Fault: Done high in cycle N+1.
  - Load / SW: Done high in cycle N+2.
  - SB/SH: Done high in cycle N+3.
- Done, Misaligned and Illegal are one-cycle pulses. Flags clear on the next edge unless a new fault is accepted.
- A new Req may be accepted in the cycle Done=1 (state is IDLE), giving back-to-back issue.
- Req while Ready=0 is ignored (no queueing). The core must hold or reissue it.
- Stores leave LoadData unchanged.
- Reset mid-operation (any non-IDLE state): next state IDLE, no write occurs (MemW gated by RST), no Done pulse. LoadData returns to 0.
- Aliasing: Addr 0x0000_1004 and 0x0000_0004 access the same word; no range error.

Test Plan:
- LW from word 5 (Addr=0x14, mem[5]=0xDEADBEEF) -> Done in cycle N+2, LoadData=0xDEADBEEF, MemW never 1.
- LB Addr=0x17 and LBU Addr=0x17, mem[5]=0x80FF1234 -> LoadData=0xFFFFFF80, then 0x00000080. LH Addr=0x16 -> 0xFFFF80FF.
- SB Addr=0x15, StoreData=0x000000AA, mem[5]=0x11223344 -> exactly one MemW cycle (N+2), mem[5]=0x1122AA44, Done in N+3. Follow with LW -> 0x1122AA44.
- SH Addr=0x13 and LW Addr=0x22 -> Misaligned=1 with Done in N+1, no MemW, memory unchanged. Load Funct3=3 -> Illegal=1.
- Back-to-back: SW 0x0000CAFE to Addr=0x8, then LW Addr=0x8 issued in the Done cycle -> LoadData=0x0000CAFE, Ready low only during LOAD/WRITE.
- RST asserted in WRITE cycle of SB to Addr=0x15 -> MemW=0, mem[5] unchanged, no Done. Next cycle Ready=1 and all outputs at reset values.
